character_motion_ctrl: RTL and testbench

//  Per-frame 2-D motion controller for the player sprite: gravity, jump impulse, terminal

---
 rtl/character_motion_ctrl_if.sv | 31 +++
 rtl/character_motion_ctrl.sv | 169 ++++++++++++++++
 tb/tb_character_motion_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/character_motion_ctrl_if.sv
// Control/collision inputs and registered sprite state outputs of character_motion_ctrl.
// master = input/collision side driving requests, slave = the motion controller.
interface character_motion_ctrl_if #(
    parameter int PW = 8,
    parameter int VW = 6
);
    logic          enable;
    logic          jump;
    logic          move_left;
    logic          move_right;
    logic          left_blocked;
    logic          right_blocked;
    logic          up_blocked;
    logic          down_blocked;
    logic [PW-1:0] x_position;
    logic [PW-1:0] y_position;
    logic [VW-1:0] y_velocity;
    logic [1:0]    motion_state;

    modport master (
        output enable, jump, move_left, move_right,
        output left_blocked, right_blocked, up_blocked, down_blocked,
        input  x_position, y_position, y_velocity, motion_state
    );

    modport slave (
        input  enable, jump, move_left, move_right,
        input  left_blocked, right_blocked, up_blocked, down_blocked,
        output x_position, y_position, y_velocity, motion_state
    );
endinterface

// File: rtl/character_motion_ctrl.sv
// Per-frame sprite motion: gravity, jump, terminal velocity, walking, collision-blocked axes.
// Optional air jump enabled by defining DOUBLE_JUMP_EN.
module character_motion_ctrl #(
    parameter int PW       = 8,
    parameter int VW       = 6,
    parameter int X_START  = 72,
    parameter int Y_START  = 0,
    parameter int X_MAX    = 152,
    parameter int Y_MAX    = 240,
    parameter int GRAVITY  = 1,
    parameter int JUMP_V   = 12,
    parameter int MAX_FALL = 8,
    parameter int X_SPEED  = 1
) (
    input  logic                     clock,
    input  logic                     resetn,
    character_motion_ctrl_if.slave   bus
);
    localparam int YW = PW + 2;

    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        RISING   = 2'd1,
        FALLING  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        x_q, x_d;
    logic [PW-1:0]        y_q, y_d;
    logic signed [VW-1:0] vy_q, vy_d;

    logic signed [VW:0]   vy_sum;
    logic signed [VW-1:0] grav_vy;
    logic signed [VW-1:0] jump_vy;
    logic signed [YW-1:0] y_ext;
    logic [PW-1:0]        grav_y;
    logic [PW-1:0]        jump_y;
    logic [PW:0]          x_sum;
    logic                 go_right;
    logic                 go_left;
    logic                 air_jump;

`ifdef DOUBLE_JUMP_EN
    logic credit_q, credit_d;
`endif

    function automatic logic [PW-1:0] clamp_y(input logic signed [YW-1:0] v);
        if (v < 0)
            return '0;
        else if (v > $signed(YW'(Y_MAX)))
            return PW'(Y_MAX);
        else
            return v[PW-1:0];
    endfunction

    always_comb begin
        vy_sum  = $signed({vy_q[VW-1], vy_q}) + $signed((VW+1)'(GRAVITY));
        grav_vy = (vy_sum > $signed((VW+1)'(MAX_FALL))) ? VW'(MAX_FALL) : vy_sum[VW-1:0];
        jump_vy = VW'(-JUMP_V);
        y_ext   = $signed({2'b00, y_q});
        grav_y  = clamp_y(y_ext + {{(YW-VW){grav_vy[VW-1]}}, grav_vy});
        jump_y  = clamp_y(y_ext - $signed(YW'(JUMP_V)));
    end

`ifdef DOUBLE_JUMP_EN
    assign air_jump = bus.jump & ~bus.up_blocked & credit_q;
`else
    assign air_jump = 1'b0;
`endif

    // Horizontal axis is independent of the vertical FSM; opposing requests cancel.
    always_comb begin
        go_right = bus.move_right & ~bus.move_left & ~bus.right_blocked;
        go_left  = bus.move_left & ~bus.move_right & ~bus.left_blocked;
        x_sum    = {1'b0, x_q} + (PW+1)'(X_SPEED);
        x_d      = x_q;
        if (go_right)
            x_d = (x_sum > (PW+1)'(X_MAX)) ? PW'(X_MAX) : x_sum[PW-1:0];
        else if (go_left)
            x_d = (x_q < PW'(X_SPEED)) ? '0 : x_q - PW'(X_SPEED);
    end

    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        vy_d     = vy_q;
`ifdef DOUBLE_JUMP_EN
        credit_d = credit_q;
`endif
        case (state_q)
            GROUNDED: begin
                if (!bus.down_blocked) begin
                    state_d = FALLING;
                    vy_d    = grav_vy;
                    y_d     = grav_y;
                end else if (bus.jump && !bus.up_blocked) begin
                    state_d = RISING;
                    vy_d    = jump_vy;
                    y_d     = jump_y;
                end else begin
                    vy_d    = '0;
                end
            end
            RISING: begin
                // A head bump takes priority over both gravity and any air jump.
                if (bus.up_blocked) begin
                    state_d = FALLING;
                    vy_d    = '0;
                end else if (air_jump) begin
                    vy_d    = jump_vy;
                    y_d     = jump_y;
`ifdef DOUBLE_JUMP_EN
                    credit_d = 1'b0;
`endif
                end else begin
                    vy_d    = grav_vy;
                    y_d     = grav_y;
                    if (!grav_vy[VW-1])
                        state_d = FALLING;
                end
            end
            FALLING: begin
                if (bus.down_blocked) begin
                    state_d = GROUNDED;
                    vy_d    = '0;
`ifdef DOUBLE_JUMP_EN
                    credit_d = 1'b1;
`endif
                end else if (air_jump) begin
                    state_d = RISING;
                    vy_d    = jump_vy;
                    y_d     = jump_y;
`ifdef DOUBLE_JUMP_EN
                    credit_d = 1'b0;
`endif
                end else begin
                    vy_d    = grav_vy;
                    y_d     = grav_y;
                end
            end
            default: state_d = FALLING;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= FALLING;
            x_q      <= PW'(X_START);
            y_q      <= PW'(Y_START);
            vy_q     <= '0;
`ifdef DOUBLE_JUMP_EN
            credit_q <= 1'b1;
`endif
        end else if (bus.enable) begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            vy_q     <= vy_d;
`ifdef DOUBLE_JUMP_EN
            credit_q <= credit_d;
`endif
        end
    end

    assign bus.x_position   = x_q;
    assign bus.y_position   = y_q;
    assign bus.y_velocity   = vy_q;
    assign bus.motion_state = state_q;
endmodule

// File: tb/tb_character_motion_ctrl.sv
// Scoreboard bench for character_motion_ctrl: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares the registered outputs.
module tb_character_motion_ctrl;
    logic clock;
    logic resetn;

    character_motion_ctrl_if bus ();

    character_motion_ctrl dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        int    x;
        int    y;
        int    vy;
        int    st;
        string name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_assert = 0;
    int   n_fail   = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            n_assert += 4;
            if (int'(bus.x_position) != mon_e.x) begin
                n_fail++;
                $display("FAIL %s x_position: got %0d expected %0d", mon_e.name, bus.x_position, mon_e.x);
            end
            if (int'(bus.y_position) != mon_e.y) begin
                n_fail++;
                $display("FAIL %s y_position: got %0d expected %0d", mon_e.name, bus.y_position, mon_e.y);
            end
            if (int'($signed(bus.y_velocity)) != mon_e.vy) begin
                n_fail++;
                $display("FAIL %s y_velocity: got %0d expected %0d", mon_e.name, $signed(bus.y_velocity), mon_e.vy);
            end
            if (int'(bus.motion_state) != mon_e.st) begin
                n_fail++;
                $display("FAIL %s motion_state: got %0d expected %0d", mon_e.name, bus.motion_state, mon_e.st);
            end
        end
    end

    task automatic push_exp(input int ex, input int ey, input int evy, input int est, input string nm);
        exp_t e;
        e.x = ex; e.y = ey; e.vy = evy; e.st = est; e.name = nm;
        exp_q.push_back(e);
    endtask

    // One enabled frame: inputs j, ml, mr, lb, rb, ub, db; expected state after the edge.
    task automatic tick(input logic j, input logic ml, input logic mr, input logic lb,
                        input logic rb, input logic ub, input logic db,
                        input int ex, input int ey, input int evy, input int est,
                        input string nm);
        @(negedge clock);
        bus.enable        = 1'b1;
        bus.jump          = j;
        bus.move_left     = ml;
        bus.move_right    = mr;
        bus.left_blocked  = lb;
        bus.right_blocked = rb;
        bus.up_blocked    = ub;
        bus.down_blocked  = db;
        @(posedge clock);
        #1;
        push_exp(ex, ey, evy, est, nm);
    endtask

    task automatic idle(input int n, input int ex, input int ey, input int evy, input int est);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            bus.enable       = 1'b0;
            bus.jump         = 1'b1;
            bus.move_right   = 1'b1;
            bus.down_blocked = 1'b1;
            @(posedge clock);
            #1;
            push_exp(ex, ey, evy, est, "enable_low_hold");
        end
    endtask

    int fall_y  [10];
    int fall_vy [10];
    int rise_y  [6];

    initial begin
        fall_y  = '{1, 3, 6, 10, 15, 21, 28, 36, 44, 52};
        fall_vy = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 8};
        rise_y  = '{67, 58, 50, 43, 37, 32};

        resetn            = 1'b0;
        bus.enable        = 1'b0;
        bus.jump          = 1'b0;
        bus.move_left     = 1'b0;
        bus.move_right    = 1'b0;
        bus.left_blocked  = 1'b0;
        bus.right_blocked = 1'b0;
        bus.up_blocked    = 1'b0;
        bus.down_blocked  = 1'b0;
        #1;
        push_exp(72, 0, 0, 2, "reset_state");
        @(negedge clock);
        #3 resetn = 1'b1;

        // Free fall from reset up to terminal velocity.
        for (int i = 0; i < 10; i++)
            tick(0, 0, 0, 0, 0, 0, 0, 72, fall_y[i], fall_vy[i], 2, "free_fall");

        idle(20, 72, 52, 8, 2);

        for (int i = 1; i <= 6; i++)
            tick(0, 0, 0, 0, 0, 0, 0, 72, 52 + 8 * i, 8, 2, "terminal_fall");
        tick(0, 0, 0, 0, 0, 0, 1, 72, 100, 0, 0, "land_100");
        tick(0, 0, 0, 0, 0, 0, 1, 72, 100, 0, 0, "grounded_hold");

        // Ground jump and rise.
        tick(1, 0, 0, 0, 0, 0, 1, 72, 88, -12, 1, "ground_jump");
        tick(0, 0, 0, 0, 0, 0, 0, 72, 77, -11, 1, "rise_first");
        for (int i = 0; i < 6; i++)
            tick(0, 0, 0, 0, 0, 0, 0, 72, rise_y[i], -10 + i, 1, "rise");

        tick(0, 0, 0, 0, 0, 1, 0, 72, 32, 0, 2, "head_bump");
        tick(0, 0, 0, 0, 0, 0, 1, 72, 32, 0, 0, "land_32");
        tick(1, 0, 0, 0, 0, 1, 1, 72, 32, 0, 0, "ceiling_jump_ignored");

        // Horizontal walking and clamps while grounded.
        for (int i = 1; i <= 79; i++)
            tick(0, 0, 1, 0, 0, 0, 1, 72 + i, 32, 0, 0, "walk_right");
        for (int i = 0; i < 3; i++)
            tick(0, 0, 1, 0, 0, 0, 1, 152, 32, 0, 0, "right_clamp");
        tick(0, 1, 1, 0, 0, 0, 1, 152, 32, 0, 0, "both_hold");
        tick(0, 1, 0, 1, 0, 0, 1, 152, 32, 0, 0, "left_blocked");
        for (int i = 1; i <= 152; i++)
            tick(0, 1, 0, 0, 0, 0, 1, 152 - i, 32, 0, 0, "walk_left");
        tick(0, 1, 0, 0, 0, 0, 1, 0, 32, 0, 0, "left_floor");
        tick(0, 0, 1, 0, 1, 0, 1, 0, 32, 0, 0, "right_blocked");
        tick(0, 0, 1, 0, 0, 0, 1, 1, 32, 0, 0, "walk_from_zero");

        // Airborne jump requests.
        tick(1, 0, 0, 0, 0, 0, 1, 1, 20, -12, 1, "jump_from_32");
`ifdef DOUBLE_JUMP_EN
        tick(1, 0, 0, 0, 0, 0, 0, 1, 8, -12, 1, "air_jump");
        tick(1, 0, 0, 0, 0, 0, 0, 1, 0, -11, 1, "second_air_jump_ignored");
`else
        tick(1, 0, 0, 0, 0, 0, 0, 1, 9, -11, 1, "air_jump_ignored");
        tick(1, 0, 0, 0, 0, 0, 0, 1, 0, -10, 1, "air_jump_ignored_clamp");
`endif

        // Asynchronous reset mid-jump.
        @(negedge clock);
        #3;
        bus.enable = 1'b0;
        resetn     = 1'b0;
        #1;
        push_exp(72, 0, 0, 2, "reset_mid_jump");
        @(negedge clock);
        #3 resetn = 1'b1;
        tick(0, 0, 0, 0, 0, 0, 0, 72, 1, 1, 2, "post_reset_fall");

        @(negedge clock);
        bus.enable = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
